muldiv_ctrl: RTL

- Sequencer for the shared multi-cycle HI/LO arithmetic resources used by the execute stage: the iterative divider (start/ready protocol) and an external fixed-latency multiplier.
- Accepts one MULT/MULTU/DIV/DIVU operation at a time and registers the operands.
- Drives the selected unit and holds the pipeline via stall_o until the 64-bit {hi,lo} result is available.
- Holds the result stable until the execute stage advances, and aborts cleanly on flush.

---
 rtl/muldiv_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_ctrl
// Purpose  : Sequencer for the shared HI/LO arithmetic resources of the
//            execute stage. Accepts one MULT/MULTU/DIV/DIVU at a time,
//            registers its operands, drives either the iterative divider
//            (start/ready handshake) or the fixed-latency multiplier, stalls
//            the pipeline until the 64-bit {hi,lo} result is captured, then
//            holds that result until the execute stage advances.
// Ports    : clk, resetn               - clock, synchronous active-low reset
//            op_valid_i, op_i          - mult/div request and opcode
//            srca_i, srcb_i            - rs / rt operands
//            flush_i, ex_stall_i       - kill / external hold of execute
//            stall_o                   - stall request to the hazard unit
//            result_o, result_valid_o  - {hi,lo} result and its valid flag
//            div_*                     - divider control, operands, result
//            mul_*                     - multiplier control, operands, result
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_ctrl #(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] srca_i,
  input  logic [31:0] srcb_i,
  input  logic        flush_i,
  input  logic        ex_stall_i,
  output logic        stall_o,
  output logic [63:0] result_o,
  output logic        result_valid_o,
  output logic        div_start_o,
  output logic        div_signed_o,
  output logic [31:0] div_opa_o,
  output logic [31:0] div_opb_o,
  output logic        div_annul_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        mul_signed_o,
  output logic [31:0] mul_opa_o,
  output logic [31:0] mul_opb_o,
  input  logic [63:0] mul_result_i
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_BUSY = 2'd1,
    MUL_BUSY = 2'd2,
    DONE     = 2'd3
  } state_t;

  // Counter reloads with MUL_LAT-1 so that the capture cycle is the one on
  // which it reads zero; 4 bits covers the full 1..15 latency range.
  localparam logic [3:0]  CNT_INIT = 4'(MUL_LAT - 1);
  localparam logic [31:0] DIV0_LO  = 32'hFFFF_FFFF;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] result_q, result_d;
  logic [31:0] div_opa_q, div_opa_d;
  logic [31:0] div_opb_q, div_opb_d;
  logic        div_signed_q, div_signed_d;
  logic [31:0] mul_opa_q, mul_opa_d;
  logic [31:0] mul_opb_q, mul_opb_d;
  logic        mul_signed_q, mul_signed_d;
  logic        accept;

  assign accept = op_valid_i & ~flush_i;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    result_d       = result_q;
    div_opa_d      = div_opa_q;
    div_opb_d      = div_opb_q;
    div_signed_d   = div_signed_q;
    mul_opa_d      = mul_opa_q;
    mul_opb_d      = mul_opb_q;
    mul_signed_d   = mul_signed_q;
    stall_o        = 1'b0;
    result_valid_o = 1'b0;
    div_start_o    = 1'b0;
    div_annul_o    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          stall_o = 1'b1;
          if (op_i[1]) begin
            div_opa_d    = srca_i;
            div_opb_d    = srcb_i;
            div_signed_d = ~op_i[0];
            // Divide by zero never reaches the divider: the fixed
            // {dividend, all-ones} pattern is produced here directly.
            if (srcb_i == 32'd0) begin
              result_d = {srca_i, DIV0_LO};
              state_d  = DONE;
            end else begin
              state_d  = DIV_BUSY;
            end
          end else begin
            mul_opa_d    = srca_i;
            mul_opb_d    = srcb_i;
            mul_signed_d = ~op_i[0];
            cnt_d        = CNT_INIT;
            state_d      = MUL_BUSY;
          end
        end
      end

      DIV_BUSY: begin
        stall_o = 1'b1;
        // Flush wins over a coincident ready; the divider is told to abort
        // and start is dropped in the same cycle.
        if (flush_i) begin
          div_annul_o = 1'b1;
          state_d     = IDLE;
        end else begin
          div_start_o = 1'b1;
          if (div_ready_i) begin
            result_d = div_result_i;
            state_d  = DONE;
          end
        end
      end

      MUL_BUSY: begin
        stall_o = 1'b1;
        if (flush_i) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          result_d = mul_result_i;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      DONE: begin
        // op_valid_i here still belongs to the finished instruction, so
        // leaving DONE always passes through IDLE before any new accept.
        result_valid_o = 1'b1;
        if (flush_i || !ex_stall_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      result_q     <= 64'd0;
      div_opa_q    <= 32'd0;
      div_opb_q    <= 32'd0;
      div_signed_q <= 1'b0;
      mul_opa_q    <= 32'd0;
      mul_opb_q    <= 32'd0;
      mul_signed_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      result_q     <= result_d;
      div_opa_q    <= div_opa_d;
      div_opb_q    <= div_opb_d;
      div_signed_q <= div_signed_d;
      mul_opa_q    <= mul_opa_d;
      mul_opb_q    <= mul_opb_d;
      mul_signed_q <= mul_signed_d;
    end
  end

  assign result_o     = result_q;
  assign div_opa_o    = div_opa_q;
  assign div_opb_o    = div_opb_q;
  assign div_signed_o = div_signed_q;
  assign mul_opa_o    = mul_opa_q;
  assign mul_opb_o    = mul_opb_q;
  assign mul_signed_o = mul_signed_q;

endmodule
`default_nettype wire
